// File: rtl/tcp_pkg.sv
// ============================================================================
// Module      : tcp_pkg
// Description : Shared TCP socket-table definitions: field widths, flag bit
//               positions, flag masks, the one-hot entry state encoding and
//               modular sequence arithmetic helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tcp_pkg;

  localparam int SEQ_W  = 32;
  localparam int SIZE_W = 16;
  localparam int FLAG_W = 8;

  // Flag bit positions in wire order
  localparam int FLAG_FIN = 0;
  localparam int FLAG_SYN = 1;
  localparam int FLAG_RST = 2;
  localparam int FLAG_PSH = 3;
  localparam int FLAG_ACK = 4;
  localparam int FLAG_URG = 5;
  localparam int FLAG_ECE = 6;
  localparam int FLAG_CWR = 7;

  localparam logic [FLAG_W-1:0] FLAGS_NONE   = '0;
  localparam logic [FLAG_W-1:0] FLAGS_ACK    = FLAG_W'(1 << FLAG_ACK);
  localparam logic [FLAG_W-1:0] FLAGS_SYNACK = FLAG_W'((1 << FLAG_SYN) | (1 << FLAG_ACK));
  localparam logic [FLAG_W-1:0] FLAGS_FINACK = FLAG_W'((1 << FLAG_FIN) | (1 << FLAG_ACK));
  localparam logic [FLAG_W-1:0] FLAGS_RST    = FLAG_W'(1 << FLAG_RST);

  // One-hot entry states; RST_EMIT is only reachable when RST handling is built in
  typedef enum logic [9:0] {
    ST_CLOSED      = 10'b00_0000_0001,
    ST_LISTEN      = 10'b00_0000_0010,
    ST_SYNACK_EMIT = 10'b00_0000_0100,
    ST_SYN_RCVD    = 10'b00_0000_1000,
    ST_EST         = 10'b00_0001_0000,
    ST_CW_EMIT     = 10'b00_0010_0000,
    ST_CLOSE_WAIT  = 10'b00_0100_0000,
    ST_LA_EMIT     = 10'b00_1000_0000,
    ST_LAST_ACK    = 10'b01_0000_0000,
    ST_RST_EMIT    = 10'b10_0000_0000
  } tcp_state_e;

  // Sequence-space addition, carry discarded
  function automatic logic [SEQ_W-1:0] seq_add(input logic [SEQ_W-1:0] a,
                                               input logic [SEQ_W-1:0] b);
    return a + b;
  endfunction

  // Zero-extend a payload byte count into sequence space
  function automatic logic [SEQ_W-1:0] size_ext(input logic [SIZE_W-1:0] s);
    return {{(SEQ_W-SIZE_W){1'b0}}, s};
  endfunction

endpackage

`default_nettype wire

// File: rtl/tcp_rto_timer.sv
// ============================================================================
// Module      : tcp_rto_timer
// Description : Retransmission timer. Free-runs while enabled, pulses
//               o_expire on the last count of the period and wraps; keeps a
//               separate retry counter for the owning socket entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcp_rto_timer #(
  parameter int RTO_CYCLES = 1024,
  parameter int MAX_RETRY  = 3,
  parameter int RETRY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic               i_retry_inc,
  input  logic               i_retry_clr,
  output logic               o_expire,
  output logic [RETRY_W-1:0] o_retry
);

  localparam int               CNT_W    = (RTO_CYCLES > 1) ? $clog2(RTO_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RTO_CYCLES - 1);

  logic [CNT_W-1:0]   r_cnt;
  logic [RETRY_W-1:0] r_retry;

  assign o_expire = i_en && !i_clr && (r_cnt == CNT_LAST);
  assign o_retry  = r_retry;

  // Period counter: clear wins, otherwise count while enabled and wrap on expiry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Retry counter: clear wins over increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retry <= '0;
    end else if (i_retry_clr) begin
      r_retry <= '0;
    end else if (i_retry_inc) begin
      r_retry <= r_retry + RETRY_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/tcp_listen_entry.sv
// ============================================================================
// Module      : tcp_listen_entry
// Description : Passive-open TCP socket entry. Walks LISTEN -> SYN_RCVD ->
//               ESTABLISHED -> CLOSE_WAIT -> LAST_ACK -> CLOSED, tracks
//               seq/ack and raises header requests to the tx header builder.
//               Optional RST handling is built in with TCP_LISTEN_RST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcp_listen_entry
  import tcp_pkg::*;
#(
  parameter int RTO_CYCLES = 1024,
  parameter int MAX_RETRY  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              listen_v_i,
  input  logic [SEQ_W-1:0]  iss_i,
  input  logic              close_v_i,
  input  logic              abort_v_i,
  output logic              valid_o,
  output logic              est_o,
  input  logic              rec_v_i,
  input  logic [SIZE_W-1:0] rec_size_i,
  input  logic [SEQ_W-1:0]  rec_seq_i,
  input  logic [SEQ_W-1:0]  rec_ack_i,
  input  logic [FLAG_W-1:0] rec_flag_i,
  input  logic              sent_v_i,
  input  logic [SIZE_W-1:0] send_size_i,
  output logic              req_v_o,
  output logic [FLAG_W-1:0] req_flag_o,
  output logic [SEQ_W-1:0]  req_seq_o,
  output logic [SEQ_W-1:0]  req_ack_o
);

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  tcp_state_e       r_state;
  logic [SEQ_W-1:0] r_seq;
  logic [SEQ_W-1:0] r_ack;
  logic             r_ack_pend;

  tcp_state_e         w_nxt_state;
  logic [SEQ_W-1:0]   w_nxt_seq;
  logic [SEQ_W-1:0]   w_nxt_ack;
  logic               w_nxt_pend;
  logic               w_nxt_req_v;
  logic [FLAG_W-1:0]  w_nxt_flag;
  logic [SEQ_W-1:0]   w_nxt_req_seq;
  logic               w_tmr_clr;
  logic               w_tmr_en;
  logic               w_retry_inc;
  logic               w_retry_clr;
  logic               w_expire;
  logic [RETRY_W-1:0] w_retry;

  logic w_rec_syn;
  logic w_rec_ackf;
  logic w_rec_fin;
  logic w_rec_inorder;
  logic w_unused_flags;

  assign w_rec_syn     = rec_v_i && rec_flag_i[FLAG_SYN];
  assign w_rec_ackf    = rec_v_i && rec_flag_i[FLAG_ACK];
  assign w_rec_fin     = rec_v_i && rec_flag_i[FLAG_FIN];
  assign w_rec_inorder = (rec_seq_i == r_ack);
  assign w_tmr_en      = (r_state == ST_SYN_RCVD);

  assign w_unused_flags = ^{rec_flag_i[FLAG_PSH], rec_flag_i[FLAG_URG],
                            rec_flag_i[FLAG_ECE], rec_flag_i[FLAG_CWR]
`ifndef TCP_LISTEN_RST_EN
                            , rec_flag_i[FLAG_RST]
`endif
                           };

`ifdef TCP_LISTEN_RST_EN
  logic [SEQ_W-1:0] r_rst_seq;
  logic [SEQ_W-1:0] w_nxt_rst_seq;
  logic             w_rec_rst;
  logic             w_rst_inwin;
  logic             w_later_state;

  assign w_rec_rst     = rec_v_i && rec_flag_i[FLAG_RST];
  assign w_rst_inwin   = w_rec_rst && w_rec_inorder;
  assign w_later_state = (r_state == ST_EST) || (r_state == ST_CW_EMIT) ||
                         (r_state == ST_CLOSE_WAIT) || (r_state == ST_LA_EMIT) ||
                         (r_state == ST_LAST_ACK);
`endif

  tcp_rto_timer #(
    .RTO_CYCLES (RTO_CYCLES),
    .MAX_RETRY  (MAX_RETRY),
    .RETRY_W    (RETRY_W)
  ) u_rto (
    .clk         (clk),
    .reset       (reset),
    .i_clr       (w_tmr_clr),
    .i_en        (w_tmr_en),
    .i_retry_inc (w_retry_inc),
    .i_retry_clr (w_retry_clr),
    .o_expire    (w_expire),
    .o_retry     (w_retry)
  );

  // Next-state, sequence tracking and timer control
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_seq   = r_seq;
    w_nxt_ack   = r_ack;
    w_nxt_pend  = r_ack_pend;
    w_tmr_clr   = 1'b0;
    w_retry_inc = 1'b0;
    w_retry_clr = 1'b0;
`ifdef TCP_LISTEN_RST_EN
    w_nxt_rst_seq = r_rst_seq;
`endif
    if (abort_v_i) begin
      w_nxt_state = ST_CLOSED;
      w_nxt_pend  = 1'b0;
      w_tmr_clr   = 1'b1;
      w_retry_clr = 1'b1;
    end else begin
      case (r_state)
        ST_CLOSED: begin
          if (listen_v_i) begin
            w_nxt_state = ST_LISTEN;
            w_nxt_seq   = iss_i;
            w_nxt_pend  = 1'b0;
            w_retry_clr = 1'b1;
          end
        end
        ST_LISTEN: begin
          if (w_rec_syn && !rec_flag_i[FLAG_ACK]) begin
            w_nxt_state = ST_SYNACK_EMIT;
            w_nxt_ack   = seq_add(rec_seq_i, SEQ_W'(1));
            w_retry_clr = 1'b1;
          end
`ifdef TCP_LISTEN_RST_EN
          else if (w_rec_ackf && !w_rec_rst) begin
            w_nxt_state   = ST_RST_EMIT;
            w_nxt_rst_seq = rec_ack_i;
          end
`endif
        end
        ST_SYNACK_EMIT: begin
          // Received segments are not buffered while a header is pending
          if (sent_v_i) begin
            w_nxt_state = ST_SYN_RCVD;
            w_nxt_seq   = seq_add(r_seq, SEQ_W'(1));
            w_tmr_clr   = 1'b1;
          end
        end
        ST_SYN_RCVD: begin
          if (w_rec_syn) begin
            w_nxt_state = ST_SYNACK_EMIT;
            w_nxt_seq   = seq_add(r_seq, {SEQ_W{1'b1}});
          end else if (w_rec_ackf && (rec_ack_i == r_seq)) begin
            w_nxt_state = ST_EST;
            w_retry_clr = 1'b1;
          end else if (w_expire) begin
            if (w_retry < RETRY_W'(MAX_RETRY)) begin
              w_nxt_state = ST_SYNACK_EMIT;
              w_nxt_seq   = seq_add(r_seq, {SEQ_W{1'b1}});
              w_retry_inc = 1'b1;
            end else begin
              w_nxt_state = ST_LISTEN;
              w_retry_clr = 1'b1;
            end
          end
        end
        ST_EST: begin
          // Sent first so a concurrent data arrival re-arms the pending ACK
          if (sent_v_i) begin
            w_nxt_seq  = seq_add(r_seq, size_ext(send_size_i));
            w_nxt_pend = 1'b0;
          end
          if (rec_v_i) begin
            if (w_rec_inorder) begin
              if (w_rec_fin) begin
                w_nxt_ack   = seq_add(seq_add(r_ack, size_ext(rec_size_i)), SEQ_W'(1));
                w_nxt_state = ST_CW_EMIT;
                w_nxt_pend  = 1'b0;
              end else begin
                w_nxt_ack = seq_add(r_ack, size_ext(rec_size_i));
                if (rec_size_i != '0) begin
                  w_nxt_pend = 1'b1;
                end
              end
            end else begin
              w_nxt_pend = 1'b1;
            end
          end
        end
        ST_CW_EMIT: begin
          if (sent_v_i) begin
            w_nxt_state = ST_CLOSE_WAIT;
            w_nxt_seq   = seq_add(r_seq, size_ext(send_size_i));
          end
        end
        ST_CLOSE_WAIT: begin
          if (sent_v_i) begin
            w_nxt_seq = seq_add(r_seq, size_ext(send_size_i));
          end
          if (close_v_i) begin
            w_nxt_state = ST_LA_EMIT;
          end
        end
        ST_LA_EMIT: begin
          if (sent_v_i) begin
            w_nxt_state = ST_LAST_ACK;
            w_nxt_seq   = seq_add(seq_add(r_seq, size_ext(send_size_i)), SEQ_W'(1));
          end
        end
        ST_LAST_ACK: begin
          if (w_rec_ackf && (rec_ack_i == r_seq)) begin
            w_nxt_state = ST_CLOSED;
          end
        end
`ifdef TCP_LISTEN_RST_EN
        ST_RST_EMIT: begin
          if (sent_v_i) begin
            w_nxt_state = ST_LISTEN;
          end
        end
`endif
        default: begin
          w_nxt_state = ST_CLOSED;
        end
      endcase
`ifdef TCP_LISTEN_RST_EN
      // An in-window reset overrides whatever the state handler decided
      if (w_rst_inwin) begin
        if (r_state == ST_SYN_RCVD) begin
          w_nxt_state = ST_LISTEN;
          w_nxt_seq   = r_seq;
          w_retry_inc = 1'b0;
          w_retry_clr = 1'b1;
        end else if (w_later_state) begin
          w_nxt_state = ST_CLOSED;
          w_nxt_pend  = 1'b0;
        end
      end
`endif
    end
  end

  // Header request decode from the upcoming state so outputs can be registered
  always_comb begin
    w_nxt_req_v   = 1'b0;
    w_nxt_flag    = FLAGS_NONE;
    w_nxt_req_seq = w_nxt_seq;
    case (w_nxt_state)
      ST_SYNACK_EMIT: begin
        w_nxt_req_v = 1'b1;
        w_nxt_flag  = FLAGS_SYNACK;
      end
      ST_EST: begin
        w_nxt_req_v = w_nxt_pend;
        w_nxt_flag  = FLAGS_ACK;
      end
      ST_CW_EMIT: begin
        w_nxt_req_v = 1'b1;
        w_nxt_flag  = FLAGS_ACK;
      end
      ST_CLOSE_WAIT: begin
        w_nxt_flag = FLAGS_ACK;
      end
      ST_LA_EMIT: begin
        w_nxt_req_v = 1'b1;
        w_nxt_flag  = FLAGS_FINACK;
      end
`ifdef TCP_LISTEN_RST_EN
      ST_RST_EMIT: begin
        w_nxt_req_v   = 1'b1;
        w_nxt_flag    = FLAGS_RST;
        w_nxt_req_seq = w_nxt_rst_seq;
      end
`endif
      default: begin
        w_nxt_req_v = 1'b0;
      end
    endcase
  end

  // State, sequence registers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_CLOSED;
      r_seq      <= '0;
      r_ack      <= '0;
      r_ack_pend <= 1'b0;
      valid_o    <= 1'b0;
      est_o      <= 1'b0;
      req_v_o    <= 1'b0;
      req_flag_o <= '0;
      req_seq_o  <= '0;
      req_ack_o  <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_seq      <= w_nxt_seq;
      r_ack      <= w_nxt_ack;
      r_ack_pend <= w_nxt_pend;
      valid_o    <= (w_nxt_state != ST_CLOSED);
      est_o      <= (w_nxt_state == ST_EST) || (w_nxt_state == ST_CLOSE_WAIT);
      req_v_o    <= w_nxt_req_v;
      req_flag_o <= w_nxt_flag;
      req_seq_o  <= w_nxt_req_seq;
      req_ack_o  <= w_nxt_ack;
    end
  end

`ifdef TCP_LISTEN_RST_EN
  // Latched acknowledgement of the offending segment, used as RST sequence
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rst_seq <= '0;
    end else begin
      r_rst_seq <= w_nxt_rst_seq;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_tcp_listen_entry.sv
// ============================================================================
// Module      : tb_tcp_listen_entry
// Description : Self-checking bench for tcp_listen_entry: a table of
//               single-cycle vectors through a full passive-open lifecycle,
//               then hand sequences for SYN-ACK retransmission, asynchronous
//               reset and received RST handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tcp_listen_entry;

  logic        clk;
  logic        reset;
  logic        listen_v_i;
  logic [31:0] iss_i;
  logic        close_v_i;
  logic        abort_v_i;
  logic        valid_o;
  logic        est_o;
  logic        rec_v_i;
  logic [15:0] rec_size_i;
  logic [31:0] rec_seq_i;
  logic [31:0] rec_ack_i;
  logic [7:0]  rec_flag_i;
  logic        sent_v_i;
  logic [15:0] send_size_i;
  logic        req_v_o;
  logic [7:0]  req_flag_o;
  logic [31:0] req_seq_o;
  logic [31:0] req_ack_o;

  int n_checks = 0;
  int n_fail   = 0;

  tcp_listen_entry #(
    .RTO_CYCLES (1024),
    .MAX_RETRY  (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .listen_v_i  (listen_v_i),
    .iss_i       (iss_i),
    .close_v_i   (close_v_i),
    .abort_v_i   (abort_v_i),
    .valid_o     (valid_o),
    .est_o       (est_o),
    .rec_v_i     (rec_v_i),
    .rec_size_i  (rec_size_i),
    .rec_seq_i   (rec_seq_i),
    .rec_ack_i   (rec_ack_i),
    .rec_flag_i  (rec_flag_i),
    .sent_v_i    (sent_v_i),
    .send_size_i (send_size_i),
    .req_v_o     (req_v_o),
    .req_flag_o  (req_flag_o),
    .req_seq_o   (req_seq_o),
    .req_ack_o   (req_ack_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        listen;
    logic [31:0] iss;
    logic        close;
    logic        abort;
    logic        rec_v;
    logic [15:0] rec_size;
    logic [31:0] rec_seq;
    logic [31:0] rec_ack;
    logic [7:0]  rec_flag;
    logic        sent;
    logic [15:0] send_size;
    logic        e_valid;
    logic        e_est;
    logic        e_req_v;
    logic [7:0]  e_flag;
    logic [31:0] e_seq;
    logic [31:0] e_ack;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic listen, input logic [31:0] iss,
                              input logic close, input logic abort,
                              input logic rec_v, input logic [15:0] rec_size,
                              input logic [31:0] rec_seq, input logic [31:0] rec_ack,
                              input logic [7:0] rec_flag,
                              input logic sent, input logic [15:0] send_size,
                              input logic e_valid, input logic e_est, input logic e_req_v,
                              input logic [7:0] e_flag, input logic [31:0] e_seq,
                              input logic [31:0] e_ack);
    vec_t v;
    v.listen = listen;   v.iss = iss;           v.close = close;   v.abort = abort;
    v.rec_v = rec_v;     v.rec_size = rec_size; v.rec_seq = rec_seq;
    v.rec_ack = rec_ack; v.rec_flag = rec_flag; v.sent = sent;     v.send_size = send_size;
    v.e_valid = e_valid; v.e_est = e_est;       v.e_req_v = e_req_v;
    v.e_flag = e_flag;   v.e_seq = e_seq;       v.e_ack = e_ack;
    return v;
  endfunction

  task automatic idle();
    listen_v_i = 0; iss_i = 0; close_v_i = 0; abort_v_i = 0;
    rec_v_i = 0; rec_size_i = 0; rec_seq_i = 0; rec_ack_i = 0; rec_flag_i = 0;
    sent_v_i = 0; send_size_i = 0;
  endtask

  // Drive one vector for exactly one rising edge, then sample just after it
  task automatic apply(input vec_t v);
    @(negedge clk);
    listen_v_i = v.listen; iss_i = v.iss; close_v_i = v.close; abort_v_i = v.abort;
    rec_v_i = v.rec_v; rec_size_i = v.rec_size; rec_seq_i = v.rec_seq;
    rec_ack_i = v.rec_ack; rec_flag_i = v.rec_flag;
    sent_v_i = v.sent; send_size_i = v.send_size;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input vec_t v);
    check({name, "_stat"}, {93'd0, valid_o, est_o, req_v_o}, {93'd0, v.e_valid, v.e_est, v.e_req_v});
    check({name, "_seqack"}, {32'd0, req_seq_o, req_ack_o}, {32'd0, v.e_seq, v.e_ack});
    if (v.e_req_v) begin
      check({name, "_flag"}, {88'd0, req_flag_o}, {88'd0, v.e_flag});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Rec flag shorthands
  localparam logic [7:0] F_SYN = 8'h02, F_ACK = 8'h10, F_FINACK = 8'h11, F_RST = 8'h04;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic seen;
    vec_t h;

    idle();
    reset = 1'b1;
    #1;
    check("reset_outputs", {valid_o, est_o, req_v_o, req_flag_o, req_seq_o, req_ack_o},
          {3'b000, 8'h00, 32'h0, 32'h0});
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    //            lst iss           cls abt rv  rsz   rseq          rack          rflag     snt ssz  | v  e  r  flag   seq           ack
    tbl.push_back(mk(1, 32'h0000_1000, 0, 0, 0, 16'd0,   32'h0,         32'h0,         8'h00,    0, 16'd0, 1, 0, 0, 8'h00, 32'h0000_1000, 32'h0));
    tbl.push_back(mk(0, 32'h0,         0, 0, 1, 16'd0,   32'h0000_5000, 32'h0,         F_SYN,    0, 16'd0, 1, 0, 1, 8'h12, 32'h0000_1000, 32'h0000_5001));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 16'd0,   32'h0,         32'h0,         8'h00,    1, 16'd0, 1, 0, 0, 8'h00, 32'h0000_1001, 32'h0000_5001));
    tbl.push_back(mk(0, 32'h0,         0, 0, 1, 16'd0,   32'h0000_5001, 32'h0000_1001, F_ACK,    0, 16'd0, 1, 1, 0, 8'h00, 32'h0000_1001, 32'h0000_5001));
    tbl.push_back(mk(0, 32'h0,         0, 0, 1, 16'd100, 32'h0000_5001, 32'h0000_1001, F_ACK,    0, 16'd0, 1, 1, 1, 8'h10, 32'h0000_1001, 32'h0000_5065));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 16'd0,   32'h0,         32'h0,         8'h00,    1, 16'd0, 1, 1, 0, 8'h00, 32'h0000_1001, 32'h0000_5065));
    tbl.push_back(mk(0, 32'h0,         0, 0, 1, 16'd10,  32'h0000_6000, 32'h0000_1001, F_ACK,    0, 16'd0, 1, 1, 1, 8'h10, 32'h0000_1001, 32'h0000_5065));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 16'd0,   32'h0,         32'h0,         8'h00,    1, 16'd0, 1, 1, 0, 8'h00, 32'h0000_1001, 32'h0000_5065));
    tbl.push_back(mk(0, 32'h0,         0, 0, 1, 16'd16,  32'h0000_5065, 32'h0000_1001, F_ACK,    1, 16'd32, 1, 1, 1, 8'h10, 32'h0000_1021, 32'h0000_5075));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 16'd0,   32'h0,         32'h0,         8'h00,    1, 16'd0, 1, 1, 0, 8'h00, 32'h0000_1021, 32'h0000_5075));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 16'd0,   32'h0,         32'h0,         8'h00,    1, 16'd8, 1, 1, 0, 8'h00, 32'h0000_1029, 32'h0000_5075));
    tbl.push_back(mk(0, 32'h0,         0, 0, 1, 16'd0,   32'h0000_5075, 32'h0000_1029, F_FINACK, 0, 16'd0, 1, 0, 1, 8'h10, 32'h0000_1029, 32'h0000_5076));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 16'd0,   32'h0,         32'h0,         8'h00,    1, 16'd0, 1, 1, 0, 8'h00, 32'h0000_1029, 32'h0000_5076));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 16'd0,   32'h0,         32'h0,         8'h00,    1, 16'd4, 1, 1, 0, 8'h00, 32'h0000_102D, 32'h0000_5076));
    tbl.push_back(mk(0, 32'h0,         1, 0, 0, 16'd0,   32'h0,         32'h0,         8'h00,    0, 16'd0, 1, 0, 1, 8'h11, 32'h0000_102D, 32'h0000_5076));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 16'd0,   32'h0,         32'h0,         8'h00,    1, 16'd0, 1, 0, 0, 8'h00, 32'h0000_102E, 32'h0000_5076));
    tbl.push_back(mk(0, 32'h0,         0, 0, 1, 16'd0,   32'h0000_5076, 32'h0000_102D, F_ACK,    0, 16'd0, 1, 0, 0, 8'h00, 32'h0000_102E, 32'h0000_5076));
    tbl.push_back(mk(0, 32'h0,         0, 0, 1, 16'd0,   32'h0000_5076, 32'h0000_102E, F_ACK,    0, 16'd0, 0, 0, 0, 8'h00, 32'h0000_102E, 32'h0000_5076));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 16'd0,   32'h0,         32'h0,         8'h00,    1, 16'd8, 0, 0, 0, 8'h00, 32'h0000_102E, 32'h0000_5076));
    tbl.push_back(mk(1, 32'hFFFF_FFFF, 0, 0, 0, 16'd0,   32'h0,         32'h0,         8'h00,    0, 16'd0, 1, 0, 0, 8'h00, 32'hFFFF_FFFF, 32'h0000_5076));
    tbl.push_back(mk(1, 32'h0000_3000, 0, 0, 0, 16'd0,   32'h0,         32'h0,         8'h00,    0, 16'd0, 1, 0, 0, 8'h00, 32'hFFFF_FFFF, 32'h0000_5076));
`ifdef TCP_LISTEN_RST_EN
    tbl.push_back(mk(0, 32'h0,         0, 0, 1, 16'd0,   32'h0,         32'h0000_1234, F_ACK,    0, 16'd0, 1, 0, 1, 8'h04, 32'h0000_1234, 32'h0000_5076));
`else
    tbl.push_back(mk(0, 32'h0,         0, 0, 1, 16'd0,   32'h0,         32'h0000_1234, F_ACK,    0, 16'd0, 1, 0, 0, 8'h00, 32'hFFFF_FFFF, 32'h0000_5076));
`endif
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 16'd0,   32'h0,         32'h0,         8'h00,    1, 16'd0, 1, 0, 0, 8'h00, 32'hFFFF_FFFF, 32'h0000_5076));
    tbl.push_back(mk(0, 32'h0,         0, 0, 1, 16'd0,   32'hFFFF_FFFF, 32'h0,         F_SYN,    0, 16'd0, 1, 0, 1, 8'h12, 32'hFFFF_FFFF, 32'h0000_0000));
    tbl.push_back(mk(0, 32'h0,         0, 0, 1, 16'd0,   32'h0,         32'h0,         F_ACK,    1, 16'd0, 1, 0, 0, 8'h00, 32'h0000_0000, 32'h0000_0000));
    tbl.push_back(mk(0, 32'h0,         0, 0, 1, 16'd0,   32'h0,         32'h0,         F_ACK,    0, 16'd0, 1, 1, 0, 8'h00, 32'h0000_0000, 32'h0000_0000));
    tbl.push_back(mk(1, 32'h0000_5555, 0, 1, 0, 16'd0,   32'h0,         32'h0,         8'h00,    0, 16'd0, 0, 0, 0, 8'h00, 32'h0000_0000, 32'h0000_0000));

    foreach (tbl[i]) begin
      apply(tbl[i]);
      check_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // SYN-ACK retransmission: three retries at RTO spacing, fourth expiry falls back to LISTEN
    do_reset();
    apply(mk(1, 32'h0000_1000, 0, 0, 0, 16'd0, 32'h0, 32'h0, 8'h00, 0, 16'd0, 0, 0, 0, 8'h00, 32'h0, 32'h0));
    apply(mk(0, 32'h0, 0, 0, 1, 16'd0, 32'h0000_5000, 32'h0, F_SYN, 0, 16'd0, 0, 0, 0, 8'h00, 32'h0, 32'h0));
    h = mk(0, 32'h0, 0, 0, 0, 16'd0, 32'h0, 32'h0, 8'h00, 1, 16'd0, 0, 0, 0, 8'h00, 32'h0, 32'h0);
    apply(h);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      seen = 1'b0;
      while (n < 1100 && !seen) begin
        @(posedge clk);
        #1;
        n++;
        if (req_v_o) seen = 1'b1;
      end
      if (k < 3) begin
        check($sformatf("rto%0d_latency", k), 96'(n), 96'd1024);
        check($sformatf("rto%0d_synack", k), {req_v_o, 15'd0, req_flag_o, req_seq_o, req_ack_o},
              {1'b1, 15'd0, 8'h12, 32'h0000_1000, 32'h0000_5001});
        apply(h);
      end else begin
        check("rto_giveup_no_req", {95'd0, seen}, 96'd0);
        check("rto_giveup_valid", {95'd0, valid_o}, 96'd1);
      end
    end
    // Back in LISTEN a fresh SYN is accepted with a new ack
    apply(mk(0, 32'h0, 0, 0, 1, 16'd0, 32'h0000_7000, 32'h0, F_SYN, 0, 16'd0, 0, 0, 0, 8'h00, 32'h0, 32'h0));
    check("relisten_synack", {req_v_o, 15'd0, req_flag_o, req_seq_o, req_ack_o},
          {1'b1, 15'd0, 8'h12, 32'h0000_1001, 32'h0000_7001});

    // Asynchronous reset in the middle of SYN_RCVD
    apply(h);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", {valid_o, est_o, req_v_o, req_flag_o, req_seq_o, req_ack_o},
          {3'b000, 8'h00, 32'h0, 32'h0});
    @(negedge clk);
    reset = 1'b0;

    // Received RST while established
    apply(mk(1, 32'h0000_0100, 0, 0, 0, 16'd0, 32'h0, 32'h0, 8'h00, 0, 16'd0, 0, 0, 0, 8'h00, 32'h0, 32'h0));
    apply(mk(0, 32'h0, 0, 0, 1, 16'd0, 32'h0000_0200, 32'h0, F_SYN, 0, 16'd0, 0, 0, 0, 8'h00, 32'h0, 32'h0));
    apply(h);
    apply(mk(0, 32'h0, 0, 0, 1, 16'd0, 32'h0000_0201, 32'h0000_0101, F_ACK, 0, 16'd0, 0, 0, 0, 8'h00, 32'h0, 32'h0));
    check("rst_pre_est", {94'd0, valid_o, est_o}, {94'd0, 2'b11});
    apply(mk(0, 32'h0, 0, 0, 1, 16'd0, 32'h0000_0999, 32'h0, F_RST, 0, 16'd0, 0, 0, 0, 8'h00, 32'h0, 32'h0));
    check("rst_out_of_window", {94'd0, valid_o, est_o}, {94'd0, 2'b11});
    apply(mk(0, 32'h0, 0, 0, 1, 16'd0, 32'h0000_0201, 32'h0, F_RST, 0, 16'd0, 0, 0, 0, 8'h00, 32'h0, 32'h0));
`ifdef TCP_LISTEN_RST_EN
    check("rst_in_window", {94'd0, valid_o, est_o}, {94'd0, 2'b00});
`else
    check("rst_ignored", {94'd0, valid_o, est_o}, {94'd0, 2'b11});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tcp_listen_entry.md
Name: tcp_listen_entry

Overview:
- Passive-open (server/responder) counterpart of the active-open socket entry; manages one listening TCP socket.
- Runs the lifecycle LISTEN -> SYN_RCVD -> ESTABLISHED -> CLOSE_WAIT -> LAST_ACK -> CLOSED.
- Tracks seq/ack numbers and raises header send requests toward the shared TCP tx header builder.
- Sits beside the active entries in the socket table; the rx parser fans validated headers into it.

Parameters:
- SEQ_W, 32, width of sequence and acknowledgement numbers.
- SIZE_W, 16, width of payload byte counts.
- FLAG_W, 8, TCP flag field width.
- RTO_CYCLES, 1024, cycles SYN_RCVD waits for the final ACK before SYN-ACK retransmit.
- MAX_RETRY, 3, number of SYN-ACK retransmits before the entry falls back to LISTEN.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- listen_v_i  in  1  arm entry: CLOSED -> LISTEN.
- iss_i  in  SEQ_W  initial send sequence, captured with listen_v_i.
- close_v_i  in  1  application close, honoured only in CLOSE_WAIT.
- abort_v_i  in  1  force CLOSED from any state.
- valid_o  out  1  entry not CLOSED.
- est_o  out  1  state is ESTABLISHED or CLOSE_WAIT (tx data allowed).
- rec_v_i  in  1  valid received header for this socket.
- rec_size_i  in  SIZE_W  received payload bytes.
- rec_seq_i  in  SEQ_W  received sequence number.
- rec_ack_i  in  SEQ_W  received ack number.
- rec_flag_i  in  FLAG_W  received flags.
- sent_v_i  in  1  a segment for this socket was transmitted.
- send_size_i  in  SIZE_W  payload bytes in that segment.
- req_v_o  out  1  request header-only segment emission.
- req_flag_o  out  FLAG_W  flags for the next segment.
- req_seq_o  out  SEQ_W  = seq_q.
- req_ack_o  out  SEQ_W  = ack_q.

Behaviour:
- Flag bit order (wire order): FIN=0, SYN=1, RST=2, PSH=3, ACK=4, URG=5, ECE=6, CWR=7.
- States, one-hot, registered: CLOSED, LISTEN, SYNACK_EMIT, SYN_RCVD, EST, CW_EMIT, CLOSE_WAIT, LA_EMIT, LAST_ACK.
- Reset: state CLOSED; seq_q, ack_q, retry counter, RTO counter and ack_pend all 0; every output 0.
- CLOSED + listen_v_i -> LISTEN; seq_q <= iss_i.
- LISTEN + rec SYN (ACK clear) -> SYNACK_EMIT; ack_q <= rec_seq_i+1.
  - Any other segment in LISTEN is dropped.
- SYNACK_EMIT:
  - req_v_o=1, flags SYN|ACK.
  - sent_v_i -> SYN_RCVD; seq_q += 1; RTO counter cleared.
- SYN_RCVD:
  - rec ACK with rec_ack_i==seq_q -> EST.
  - Timer expires (count reaches RTO_CYCLES-1): retry < MAX_RETRY -> SYNACK_EMIT, seq_q -= 1, retry += 1; otherwise -> LISTEN, retry cleared.
  - Duplicate SYN -> SYNACK_EMIT, same seq rewind.
- EST, in-order segment (rec_seq_i==ack_q):
  - ack_q += rec_size_i.
  - Size > 0 sets ack_pend.
  - FIN set -> ack_q += rec_size_i+1, go to CW_EMIT.
- EST, out-of-order segment: ack_q unchanged, ack_pend set (duplicate ACK).
- EST, ack_pend: req_v_o=1, flags ACK.
- EST, sent_v_i: seq_q += send_size_i; clears ack_pend (data segments piggyback the ACK).
- CW_EMIT: flags ACK; sent_v_i -> CLOSE_WAIT.
- CLOSE_WAIT: tx data still allowed; close_v_i -> LA_EMIT.
- LA_EMIT: flags FIN|ACK; sent_v_i -> LAST_ACK; seq_q += send_size_i+1.
- LAST_ACK: rec ACK with rec_ack_i==seq_q -> CLOSED.
- Outputs are registered.
  - req_v_o rises the cycle after entering an emit state or setting ack_pend.
  - req_v_o drops the cycle after sent_v_i.
- sent_v_i with req_v_o=0 outside EST/CLOSE_WAIT: ignored.
- rec_v_i and sent_v_i in the same cycle: both applied; seq from sent, ack from rec.
- rec_v_i coincident with an emit-state sent_v_i: transition on sent first; rec is evaluated against the new state the next time only if it is re-presented (no buffering).
- abort_v_i takes priority over every other input; listen_v_i outside CLOSED is ignored.
- All seq/ack arithmetic is modulo 2^SEQ_W with carry discarded; sizes are zero-extended.

Optional Feature:
- Macro: TCP_LISTEN_RST_EN.
- Defined:
  - Received RST with in-window seq (==ack_q) in SYN_RCVD -> LISTEN.
  - Received RST with in-window seq in any later state -> CLOSED.
  - ACK received in LISTEN -> RST_EMIT state: req_v_o with flags RST, req_seq_o = rec_ack_i (latched); sent_v_i -> LISTEN.
- Undefined: RST flags are ignored, no RST_EMIT state, LISTEN silently drops ACKs.

Decomposition:
- Shared package tcp_pkg holds:
  - SEQ_W, SIZE_W, FLAG_W;
  - flag index constants;
  - state enum typedef;
  - modular seq add helper function.
- One sub-module, tcp_rto_timer: counter with clear/enable/expire pulse and retry count, reusable by the active entry.

Test Plan:
- listen_v_i with iss=0x1000; rec SYN seq=0x5000 -> req SYN|ACK with seq 0x1000, ack 0x5001; sent; rec ACK with ack=0x1001 -> est_o=1.
- EST; rec seq=0x5001 size=100 -> req ACK with ack 0x5065; sent with size 0 -> req_v_o low the next cycle.
- SYN_RCVD with no ACK -> SYN-ACK re-requested after 1024 cycles with seq 0x1000, 3 times; 4th expiry -> LISTEN.
- rec FIN seq=0x5065 size=0 -> ACK with ack 0x5066; close_v_i -> FIN|ACK seq=S; rec ack=S+1 -> valid_o=0.
- Out-of-order rec seq=0x6000 -> dup ACK with ack unchanged; simultaneous rec and sent in EST -> both counters update.
- reset asserted mid-SYN_RCVD (asynchronous) -> all outputs 0 immediately; RST_EN: RST in EST -> CLOSED.
